// File: rtl/cpu_out_uart_tx.sv
// Queues CPUOut words from the core and shifts each one out on TxD as four
// UART byte frames, LSB byte first. Define CPU_OUT_UART_PARITY_EN for 8E1 frames.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high; pops the FIFO head when a word is queued
// S_START  | start bit (low) for one bit time
// S_DATA   | eight data bits of the current byte, LSB first
// S_PARITY | even parity of the current byte (parity builds only)
// S_STOP   | stop bit (high); next byte of the word or back to idle
module cpu_out_uart_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                         CLK,
  input  logic                         ResetN,
  input  logic [31:0]                  CPUOut,
  input  logic                         OutWrite,
  output logic                         TxD,
  output logic                         Busy,
  output logic                         Empty,
  output logic                         Full,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);

`ifdef CPU_OUT_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q;
  logic            txd_q;
  logic            busy_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_idx_q;
  logic [1:0]      byte_idx_q;
  logic [31:0]     shift_q;

  logic [31:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, full_q;
  logic            overflow_q, overflow_d;

  logic            push, pop;
  logic [7:0]      cur_byte;
  logic [2:0]      bit_nxt;

  // A full FIFO still accepts a write when the idle serializer frees a slot on the same edge.
  assign pop      = (state_q == S_IDLE) && !empty_q;
  assign push     = OutWrite && (!full_q || pop);
  assign cur_byte = shift_q[7:0];
  assign bit_nxt  = bit_idx_q + 3'd1;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (OutWrite & ~push);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CNT_FULL);
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= CPUOut;
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            timer_q    <= TIMER_LOAD;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end

        S_START: begin
          if (timer_q == '0) begin
            timer_q   <= TIMER_LOAD;
            bit_idx_q <= '0;
            txd_q     <= cur_byte[0];
            state_q   <= S_DATA;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        S_DATA: begin
          if (timer_q == '0) begin
            timer_q <= TIMER_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
              txd_q   <= ^cur_byte;
              state_q <= S_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_nxt;
              txd_q     <= cur_byte[bit_nxt];
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

`ifdef CPU_OUT_UART_PARITY_EN
        S_PARITY: begin
          if (timer_q == '0) begin
            timer_q <= TIMER_LOAD;
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif

        S_STOP: begin
          if (timer_q == '0) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              shift_q    <= {8'h00, shift_q[31:8]};
              timer_q    <= TIMER_LOAD;
              txd_q      <= 1'b0;
              state_q    <= S_START;
            end else begin
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TxD      = txd_q;
  assign Busy     = busy_q;
  assign Empty    = empty_q;
  assign Full     = full_q;
  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule
